dmem_arbiter: RTL

//  Arbitrates one single-port data memory between two requesters: M0 = CPU

---
 rtl/dmem_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for a single-port data memory.
// Each access is sequenced IDLE -> ACCESS -> WAIT -> DONE with range checking.
module dmem_arbiter #(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_we,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_we,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT        = CNT_W'(RD_LAT);
    localparam logic [31:0]      ADDR_LIMIT = 32'(MEM_BYTES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             last, last_d;
    logic             lat_err, lat_err_d;
    logic [3:0]       lat_we, lat_we_d;
    logic             owner_d;
    logic [31:0]      mem_addr_d, mem_wdata_d;
    logic [3:0]       mem_we_d;
    logic             mem_en_d, busy_d, done_d;
    logic             m0_ack_d, m1_ack_d, m0_err_d, m1_err_d;
    logic [31:0]      m0_rdata_d, m1_rdata_d;

    logic             sel;
    logic [31:0]      sel_addr, sel_wdata;
    logic [3:0]       sel_we;

    // Round-robin pick: on a tie the requester not served last wins
    always_comb begin
        sel       = (m0_req && m1_req) ? ~last : m1_req;
        sel_addr  = sel ? m1_addr  : m0_addr;
        sel_wdata = sel ? m1_wdata : m0_wdata;
        sel_we    = sel ? m1_we    : m0_we;
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        last_d      = last;
        lat_err_d   = lat_err;
        lat_we_d    = lat_we;
        owner_d     = owner;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        m0_rdata_d  = m0_rdata;
        m1_rdata_d  = m1_rdata;

        case (state)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d  = sel;
                    last_d   = sel;
                    lat_we_d = sel_we;
                    if (sel_addr >= ADDR_LIMIT) begin
                        lat_err_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        lat_err_d   = 1'b0;
                        mem_addr_d  = {sel_addr[31:2], 2'b00};
                        mem_wdata_d = sel_wdata;
                        state_d     = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (lat_we != 4'h0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == LAT) begin
                    if (owner) m1_rdata_d = mem_rdata;
                    else       m0_rdata_d = mem_rdata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        mem_en_d = (state_d == S_ACCESS);
        mem_we_d = (state_d == S_ACCESS) ? lat_we_d : 4'h0;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        m0_ack_d = done_d && !owner_d;
        m1_ack_d = done_d && owner_d;
        m0_err_d = m0_ack_d && lat_err_d;
        m1_err_d = m1_ack_d && lat_err_d;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            last      <= 1'b1;
            lat_err   <= 1'b0;
            lat_we    <= 4'h0;
            owner     <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 4'h0;
            busy      <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            cnt       <= cnt_d;
            last      <= last_d;
            lat_err   <= lat_err_d;
            lat_we    <= lat_we_d;
            owner     <= owner_d;
            mem_en    <= mem_en_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_we    <= mem_we_d;
            busy      <= busy_d;
            m0_ack    <= m0_ack_d;
            m1_ack    <= m1_ack_d;
            m0_err    <= m0_err_d;
            m1_err    <= m1_err_d;
            m0_rdata  <= m0_rdata_d;
            m1_rdata  <= m1_rdata_d;
        end
    end

endmodule
